// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming dig-tool arbiter and the walker FSMs.
//   - slot_state_t : per-lemming tool-holding state (IDLE, PEND, DIG, COOL)
//   - TIMER_W      : width of the ack-timeout / cooldown timers
//   - WALK_*       : walker state encodings, shared with the walker FSM so
//                    both sides agree on what "digging" means
//   - wrap_add     : modular index helper for the round-robin picker
package lemmings_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_DIG  = 2'd2,
        SLOT_COOL = 2'd3
    } slot_state_t;

    // Walker state encodings. The walker drives its digging output while in
    // WALK_DIG_LEFT / WALK_DIG_RIGHT.
    localparam int         WALKER_STATE_W  = 3;
    localparam logic [2:0] WALK_LEFT       = 3'd0;
    localparam logic [2:0] WALK_RIGHT      = 3'd1;
    localparam logic [2:0] WALK_FALL_LEFT  = 3'd2;
    localparam logic [2:0] WALK_FALL_RIGHT = 3'd3;
    localparam logic [2:0] WALK_DIG_LEFT   = 3'd4;
    localparam logic [2:0] WALK_DIG_RIGHT  = 3'd5;
    localparam logic [2:0] WALK_SPLATTER   = 3'd6;

    // (base + off) mod n, for base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/lemming_dig_slot.sv
// Per-lemming tool-holding FSM with its ack/cooldown timer.
//   clk, reset   : clock, synchronous active-high reset
//   grant        : arbiter selected this lemming this cycle (only while idle)
//   digging      : walker reports it is digging
//   dig          : registered one-cycle dig command (cycle after grant)
//   granted      : registered, high while the lemming holds a tool
//   idle         : FSM is in IDLE (eligible for arbitration)
//   tool_return  : combinational, high in the cycle the tool is given back
module lemming_dig_slot
    import lemmings_pkg::*;
#(
    parameter int ACK_TIMEOUT = 3,
    parameter int COOLDOWN    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic grant,
    input  logic digging,
    output logic dig,
    output logic granted,
    output logic idle,
    output logic tool_return
);

    localparam logic [TIMER_W-1:0] ACK_LOAD  = TIMER_W'(ACK_TIMEOUT);
    // COOL is held while the timer counts COOL_LOAD down to 0, so loading
    // COOLDOWN-1 gives exactly COOLDOWN cycles in COOL.
    localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    slot_state_t         state_reg, state_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic                dig_reg;
    logic                granted_reg;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        tool_return = 1'b0;
        case (state_reg)
            SLOT_IDLE: begin
                if (grant) begin
                    state_next = SLOT_PEND;
                    timer_next = ACK_LOAD;
                end
            end
            SLOT_PEND: begin
                if (digging) begin
                    state_next = SLOT_DIG;
                end else if (timer_reg == '0) begin
                    // Walker never started (falling or dead): reclaim the tool.
                    tool_return = 1'b1;
                    if (COOLDOWN == 0) begin
                        state_next = SLOT_IDLE;
                    end else begin
                        state_next = SLOT_COOL;
                        timer_next = COOL_LOAD;
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            SLOT_DIG: begin
                if (!digging) begin
                    tool_return = 1'b1;
                    if (COOLDOWN == 0) begin
                        state_next = SLOT_IDLE;
                    end else begin
                        state_next = SLOT_COOL;
                        timer_next = COOL_LOAD;
                    end
                end
            end
            SLOT_COOL: begin
                if (timer_reg == '0) begin
                    state_next = SLOT_IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = SLOT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= SLOT_IDLE;
            timer_reg   <= '0;
            dig_reg     <= 1'b0;
            granted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            // grant is only ever raised while idle, so it maps 1:1 to a pulse.
            dig_reg     <= grant;
            granted_reg <= (state_next == SLOT_PEND) || (state_next == SLOT_DIG);
        end
    end

    assign dig     = dig_reg;
    assign granted = granted_reg;
    assign idle    = (state_reg == SLOT_IDLE);

endmodule

// File: rtl/lemming_dig_arbiter.sv
// Shares a pool of TOOLS digging tools among N lemming walkers.
// Round-robin picks at most one idle requester per cycle while a tool is
// free; each per-lemming slot then tracks the tool until the walker stops
// digging or fails to start within ACK_TIMEOUT cycles.
//   clk, reset  : clock, synchronous active-high reset
//   req[N]      : lemming i wants to dig (level)
//   digging[N]  : lemming i's walker is digging
//   dig[N]      : one-cycle dig command to lemming i
//   granted[N]  : lemming i holds a tool
//   tools_free  : number of unallocated tools (registered)
//   all_busy    : tools_free == 0
module lemming_dig_arbiter
    import lemmings_pkg::*;
#(
    parameter int N           = 4,
    parameter int TOOLS       = 2,
    parameter int ACK_TIMEOUT = 3,
    parameter int COOLDOWN    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               req,
    input  logic [N-1:0]               digging,
    output logic [N-1:0]               dig,
    output logic [N-1:0]               granted,
    output logic [$clog2(TOOLS+1)-1:0] tools_free,
    output logic                       all_busy
);

    localparam int TF_W  = $clog2(TOOLS + 1);
    localparam int PTR_W = $clog2(N);

    logic [TF_W-1:0]  tools_free_reg, tools_free_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [N-1:0]     slot_idle;
    logic [N-1:0]     tool_return;
    logic [N-1:0]     eligible;
    logic [N-1:0]     grant_vec;
    logic             grant_any;
    logic [PTR_W-1:0] winner;
    logic [TF_W-1:0]  ret_count;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            lemming_dig_slot #(
                .ACK_TIMEOUT (ACK_TIMEOUT),
                .COOLDOWN    (COOLDOWN)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .grant       (grant_vec[gi]),
                .digging     (digging[gi]),
                .dig         (dig[gi]),
                .granted     (granted[gi]),
                .idle        (slot_idle[gi]),
                .tool_return (tool_return[gi])
            );
            // Uses the registered count, so a tool returned this cycle only
            // becomes grantable next cycle.
            assign eligible[gi] = slot_idle[gi] & req[gi] & (tools_free_reg != '0);
        end
    endgenerate

    // First eligible index at or after the pointer, wrapping N-1 -> 0.
    always_comb begin
        int idx;
        grant_vec = '0;
        grant_any = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = wrap_add(int'(ptr_reg), k, N);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                winner    = PTR_W'(idx);
            end
        end
        if (grant_any) begin
            grant_vec[winner] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (winner == PTR_W'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Returns only come from held tools, so the sum stays within TOOLS, and
    // a grant only happens with tools_free_reg > 0, so no underflow.
    always_comb begin
        ret_count = '0;
        for (int k = 0; k < N; k++) begin
            ret_count = ret_count + TF_W'(tool_return[k]);
        end
        tools_free_next = tools_free_reg + ret_count - TF_W'(grant_any);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tools_free_reg <= TF_W'(TOOLS);
            ptr_reg        <= '0;
        end else begin
            tools_free_reg <= tools_free_next;
            ptr_reg        <= ptr_next;
        end
    end

    assign tools_free = tools_free_reg;
    assign all_busy   = (tools_free_reg == '0);

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Directed bench for lemming_dig_arbiter with N=4, TOOLS=2, ACK_TIMEOUT=3,
// COOLDOWN=2. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge of the same cycle.
module tb_lemming_dig_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] digging = 4'b0000;
    logic [3:0] dig;
    logic [3:0] granted;
    logic [1:0] tools_free;
    logic       all_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lemming_dig_arbiter #(
        .N           (4),
        .TOOLS       (2),
        .ACK_TIMEOUT (3),
        .COOLDOWN    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .digging    (digging),
        .dig        (dig),
        .granted    (granted),
        .tools_free (tools_free),
        .all_busy   (all_busy)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] digging;
        logic [3:0] dig;
        logic [3:0] granted;
        logic [1:0] tf;
        logic       busy;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [3:0] e_dig, input logic [3:0] e_gr,
                            input logic [1:0] e_tf, input logic e_busy);
        chk({nm, ".dig"}, 32'(dig), 32'(e_dig));
        chk({nm, ".granted"}, 32'(granted), 32'(e_gr));
        chk({nm, ".tools_free"}, 32'(tools_free), 32'(e_tf));
        chk({nm, ".all_busy"}, 32'(all_busy), 32'(e_busy));
        $display("%s req=%b digging=%b dig=%b granted=%b tools_free=%0d all_busy=%b",
                 nm, req, digging, dig, granted, tools_free, all_busy);
    endtask

    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] d);
        @(posedge clk);
        #1;
        reset   = rst;
        req     = r;
        digging = d;
        @(negedge clk);
    endtask

    // The pool can never hold more than TOOLS free tools.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            total++;
            if (!(tools_free <= 2'd2)) begin
                bad++;
                $display("FAIL tools_free_range got=%0d want<=2", tools_free);
            end
        end
    end

    initial begin
        logic [3:0] dseen;
        logic [3:0] e_dig;
        logic [3:0] e_gr;
        logic [1:0] e_tf;

        // Single requester, cooldown, then a timeout on lemming 3 and a
        // digging rise on an idle lemming that must be ignored.
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b0};
        tbl[3]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[4]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[5]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[6]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[7]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[8]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[9]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[10] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0};
        tbl[11] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[12] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[13] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[14] = '{4'b1000, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b0};
        tbl[15] = '{4'b0000, 4'b0000, 4'b1000, 4'b1010, 2'd0, 1'b1};
        tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 2'd0, 1'b1};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 2'd0, 1'b1};
        tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd1, 1'b0};
        tbl[19] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[20] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[21] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};

        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 22; i++) begin
            step(1'b0, tbl[i].req, tbl[i].digging);
            chk_outs($sformatf("vec%0d", i), tbl[i].dig, tbl[i].granted, tbl[i].tf, tbl[i].busy);
        end

        // Contention: all request, walkers echo dig one cycle later.
        step(1'b1, 4'b0000, 4'b0000);
        dseen = 4'b0000;
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 4'b1111, dseen);
            e_dig = (c == 1) ? 4'b0001 : (c == 2) ? 4'b0010 : 4'b0000;
            e_gr  = (c == 0) ? 4'b0000 : (c == 1) ? 4'b0001 : 4'b0011;
            e_tf  = (c == 0) ? 2'd2 : (c == 1) ? 2'd1 : 2'd0;
            chk_outs($sformatf("contend%0d", c), e_dig, e_gr, e_tf, (e_tf == 2'd0));
            dseen = dseen | dig;
        end

        // Return and request in the same cycle: lemming 0 stops, lemming 2 asks.
        step(1'b0, 4'b0100, 4'b0010);
        chk_outs("simul0", 4'b0000, 4'b0011, 2'd0, 1'b1);
        step(1'b0, 4'b0100, 4'b0010);
        chk_outs("simul1", 4'b0000, 4'b0010, 2'd1, 1'b0);
        step(1'b0, 4'b0000, 4'b0010);
        chk_outs("simul2", 4'b0100, 4'b0110, 2'd0, 1'b1);
        step(1'b0, 4'b0000, 4'b0110);
        chk_outs("simul3", 4'b0000, 4'b0110, 2'd0, 1'b1);

        // Reset while lemmings 1 and 2 are digging.
        step(1'b1, 4'b1111, 4'b0110);
        step(1'b0, 4'b1111, 4'b0110);
        chk_outs("rst_mid0", 4'b0000, 4'b0000, 2'd2, 1'b0);
        step(1'b0, 4'b0000, 4'b0110);
        chk_outs("rst_mid1", 4'b0001, 4'b0001, 2'd1, 1'b0);

        // Round-robin wrap: grant lemming 2 to move the pointer to 3.
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        chk_outs("wrap_setup", 4'b0100, 4'b0100, 2'd1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 4'b0000, 4'b0000);
        end
        chk_outs("wrap_idle", 4'b0000, 4'b0000, 2'd2, 1'b0);
        step(1'b0, 4'b1001, 4'b0000);
        chk_outs("wrap0", 4'b0000, 4'b0000, 2'd2, 1'b0);
        step(1'b0, 4'b1001, 4'b0000);
        chk_outs("wrap1", 4'b1000, 4'b1000, 2'd1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000);
        chk_outs("wrap2", 4'b0001, 4'b1001, 2'd0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b0000, 4'b0000);
        end
        chk_outs("wrap_drain", 4'b0000, 4'b0000, 2'd2, 1'b0);
        // Pointer is now 1: with lemmings 0 and 1 asking, 1 wins.
        step(1'b0, 4'b0011, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        chk_outs("wrap_ptr1", 4'b0010, 4'b0010, 2'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
